// File: rtl/mt_pkg.sv
// mt_pkg: shared types, default sizes and reset mapping for the checkpointed rename map table
package mt_pkg;
    localparam int ARCH_REGS_DEF  = 32;
    localparam int PHYS_REGS_DEF  = 64;
    localparam int DISPATCH_W_DEF = 2;
    localparam int CDB_W_DEF      = 1;
    localparam int CKPT_N_DEF     = 4;
    localparam int PW_DEF         = $clog2(PHYS_REGS_DEF);
    localparam int CW_DEF         = $clog2(CKPT_N_DEF);
    typedef struct packed {
        logic              ready;
        logic [PW_DEF-1:0] tag;
    } MT_ENTRY;
    typedef logic [CW_DEF-1:0] CKPT_ID;
    function automatic MT_ENTRY reset_entry(input int i);
        return '{ready: 1'b1, tag: PW_DEF'(i)};
    endfunction
endpackage

// File: rtl/map_ckpt_alloc.sv
// map_ckpt_alloc: checkpoint live bits, older-masks, lowest-free allocation and cascading release
module map_ckpt_alloc
    import mt_pkg::*;
#(
    parameter  int CKPT_N = CKPT_N_DEF,
    localparam int CW     = $clog2(CKPT_N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          take_i,
    input  logic          restore_en_i,
    input  logic [CW-1:0] restore_id_i,
    input  logic          free_en_i,
    input  logic [CW-1:0] free_id_i,
    output logic [CW-1:0] ckpt_id_o,
    output logic          ckpt_full_o,
    output logic          restore_ok_o,
    output logic          take_ok_o
);
    logic [CKPT_N-1:0]             live_q, live_d, kill, free_m;
    logic [CKPT_N-1:0][CKPT_N-1:0] older_q, older_d;
    logic                          free_ok;

    assign restore_ok_o = restore_en_i && live_q[restore_id_i];
    assign ckpt_full_o  = &live_q;
    assign take_ok_o    = take_i && !ckpt_full_o && !restore_ok_o;

    always_comb begin
        ckpt_id_o = '0;
        for (int i = CKPT_N - 1; i >= 0; i--)
            if (!live_q[i]) ckpt_id_o = CW'(i);
    end

    // A restore kills its own checkpoint and every younger one that recorded it as older
    always_comb begin
        kill = '0;
        for (int i = 0; i < CKPT_N; i++)
            kill[i] = restore_ok_o && (CW'(i) == restore_id_i || older_q[i][restore_id_i]);
    end

    assign free_ok = free_en_i && live_q[free_id_i] && !kill[free_id_i];
    assign free_m  = free_ok ? CKPT_N'(1) << free_id_i : '0;

    always_comb begin
        live_d = live_q & ~kill & ~free_m;
        for (int i = 0; i < CKPT_N; i++)
            older_d[i] = older_q[i] & ~kill & ~free_m;
        if (take_ok_o) begin
            live_d[ckpt_id_o]  = 1'b1;
            older_d[ckpt_id_o] = live_q & ~free_m;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q  <= '0;
            older_q <= '0;
        end else begin
            live_q  <= live_d;
            older_q <= older_d;
        end
    end
endmodule

// File: rtl/map_table_ckpt.sv
// map_table_ckpt: multi-way rename map table with CDB ready updates and branch checkpoints
module map_table_ckpt
    import mt_pkg::*;
#(
    parameter  int ARCH_REGS  = ARCH_REGS_DEF,
    parameter  int PHYS_REGS  = PHYS_REGS_DEF,
    parameter  int DISPATCH_W = DISPATCH_W_DEF,
    parameter  int CDB_W      = CDB_W_DEF,
    parameter  int CKPT_N     = CKPT_N_DEF,
    localparam int AW         = $clog2(ARCH_REGS),
    localparam int PW         = $clog2(PHYS_REGS),
    localparam int CW         = $clog2(CKPT_N)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [DISPATCH_W-1:0][1:0][AW-1:0]  rd_idx_i,
    output logic [DISPATCH_W-1:0][1:0][PW:0]    rd_tag_o,
    input  logic [DISPATCH_W-1:0]               wr_en_i,
    input  logic [DISPATCH_W-1:0][AW-1:0]       wr_idx_i,
    input  logic [DISPATCH_W-1:0][PW-1:0]       wr_tag_i,
    output logic [DISPATCH_W-1:0][PW-1:0]       told_o,
    input  logic [CDB_W-1:0]                    cdb_valid_i,
    input  logic [CDB_W-1:0][PW-1:0]            cdb_tag_i,
    input  logic                                ckpt_take_i,
    output logic [CW-1:0]                       ckpt_id_o,
    output logic                                ckpt_full_o,
    input  logic                                restore_en_i,
    input  logic [CW-1:0]                       restore_id_i,
    input  logic                                free_en_i,
    input  logic [CW-1:0]                       free_id_i
);
    typedef struct packed {
        logic          ready;
        logic [PW-1:0] tag;
    } entry_t;

    entry_t table_q [ARCH_REGS];
    entry_t table_d [ARCH_REGS];
    entry_t snap_q  [CKPT_N][ARCH_REGS];
    entry_t snap_d  [CKPT_N][ARCH_REGS];
    logic   restore_ok, take_ok;

    function automatic logic hit(input logic [PW-1:0] t, input logic [CDB_W-1:0] v,
                                 input logic [CDB_W-1:0][PW-1:0] tags);
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) hit = hit | (v[c] && tags[c] == t);
    endfunction

    map_ckpt_alloc #(.CKPT_N(CKPT_N)) u_alloc (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .take_i       (ckpt_take_i),
        .restore_en_i (restore_en_i),
        .restore_id_i (restore_id_i),
        .free_en_i    (free_en_i),
        .free_id_i    (free_id_i),
        .ckpt_id_o    (ckpt_id_o),
        .ckpt_full_o  (ckpt_full_o),
        .restore_ok_o (restore_ok),
        .take_ok_o    (take_ok)
    );

    // Later slots see earlier slots' renames; the youngest earlier writer wins
    always_comb begin
        entry_t        e;
        logic [AW-1:0] idx;
        logic [PW-1:0] t;
        e   = '0;
        idx = '0;
        t   = '0;
        for (int j = 0; j < DISPATCH_W; j++) begin
            for (int s = 0; s < 2; s++) begin
                idx     = rd_idx_i[j][s];
                e       = table_q[idx];
                e.ready = e.ready | hit(e.tag, cdb_valid_i, cdb_tag_i);
                for (int k = 0; k < j; k++)
                    if (wr_en_i[k] && wr_idx_i[k] == idx && idx != '0) e = '{1'b0, wr_tag_i[k]};
                rd_tag_o[j][s] = e;
            end
            t = table_q[wr_idx_i[j]].tag;
            for (int k = 0; k < j; k++)
                if (wr_en_i[k] && wr_idx_i[k] == wr_idx_i[j] && wr_idx_i[j] != '0) t = wr_tag_i[k];
            told_o[j] = t;
        end
    end

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            table_d[i]       = table_q[i];
            table_d[i].ready = table_q[i].ready | hit(table_q[i].tag, cdb_valid_i, cdb_tag_i);
        end
        for (int k = 0; k < DISPATCH_W; k++)
            if (wr_en_i[k] && wr_idx_i[k] != '0) table_d[wr_idx_i[k]] = '{1'b0, wr_tag_i[k]};
        if (restore_ok)
            for (int i = 0; i < ARCH_REGS; i++) begin
                table_d[i]       = snap_q[restore_id_i][i];
                table_d[i].ready = snap_q[restore_id_i][i].ready
                                 | hit(snap_q[restore_id_i][i].tag, cdb_valid_i, cdb_tag_i);
            end
    end

    always_comb begin
        for (int c = 0; c < CKPT_N; c++)
            for (int i = 0; i < ARCH_REGS; i++) begin
                snap_d[c][i]       = snap_q[c][i];
                snap_d[c][i].ready = snap_q[c][i].ready | hit(snap_q[c][i].tag, cdb_valid_i, cdb_tag_i);
                if (take_ok && CW'(c) == ckpt_id_o) snap_d[c][i] = table_d[i];
            end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ARCH_REGS; i++) table_q[i] <= '{1'b1, PW'(i)};
            for (int c = 0; c < CKPT_N; c++)
                for (int i = 0; i < ARCH_REGS; i++) snap_q[c][i] <= '{1'b1, PW'(i)};
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) table_q[i] <= table_d[i];
            for (int c = 0; c < CKPT_N; c++)
                for (int i = 0; i < ARCH_REGS; i++) snap_q[c][i] <= snap_d[c][i];
        end
    end
endmodule

// File: tb/tb_map_table_ckpt.sv
// tb_map_table_ckpt: directed self-checking bench for the checkpointed rename map table
module tb_map_table_ckpt;
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0][1:0][4:0] rd_idx;
    logic [1:0][1:0][6:0] rd_tag;
    logic [1:0]           wr_en;
    logic [1:0][4:0]      wr_idx;
    logic [1:0][5:0]      wr_tag;
    logic [1:0][5:0]      told;
    logic [0:0]           cdb_valid;
    logic [0:0][5:0]      cdb_tag;
    logic                 ckpt_take, ckpt_full, restore_en, free_en;
    logic [1:0]           ckpt_id, restore_id, free_id;
    int                   n_cmp = 0;
    int                   n_bad = 0;

    map_table_ckpt dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_idx_i     (rd_idx),
        .rd_tag_o     (rd_tag),
        .wr_en_i      (wr_en),
        .wr_idx_i     (wr_idx),
        .wr_tag_i     (wr_tag),
        .told_o       (told),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .ckpt_take_i  (ckpt_take),
        .ckpt_id_o    (ckpt_id),
        .ckpt_full_o  (ckpt_full),
        .restore_en_i (restore_en),
        .restore_id_i (restore_id),
        .free_en_i    (free_en),
        .free_id_i    (free_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd_idx     = '0;
        wr_en      = '0;
        wr_idx     = '0;
        wr_tag     = '0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        ckpt_take  = 1'b0;
        restore_en = 1'b0;
        restore_id = '0;
        free_en    = 1'b0;
        free_id    = '0;
    endtask

    // Entry encoding seen on rd_tag: {ready, tag}, so ready=1 adds 64
    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_idx[0][0] = 5'd1;
        rd_idx[0][1] = 5'd2;
        #1;
        chk("reset_r1", 32'(rd_tag[0][0]), 65);
        chk("reset_r2", 32'(rd_tag[0][1]), 66);
        chk("reset_id", 32'(ckpt_id), 0);
        chk("reset_full", 32'(ckpt_full), 0);

        idle();
        wr_en        = 2'b11;
        wr_idx[0]    = 5'd3;
        wr_tag[0]    = 6'd40;
        wr_idx[1]    = 5'd3;
        wr_tag[1]    = 6'd41;
        rd_idx[0][0] = 5'd3;
        rd_idx[1][0] = 5'd3;
        #1;
        chk("byp_slot0", 32'(rd_tag[0][0]), 67);
        chk("byp_slot1", 32'(rd_tag[1][0]), 40);
        chk("told0", 32'(told[0]), 3);
        chk("told1", 32'(told[1]), 40);
        tick();
        idle();
        rd_idx[0][0] = 5'd3;
        #1;
        chk("r3_after", 32'(rd_tag[0][0]), 41);

        wr_en     = 2'b01;
        wr_idx[0] = 5'd5;
        wr_tag[0] = 6'd40;
        tick();
        idle();
        cdb_valid    = 1'b1;
        cdb_tag[0]   = 6'd40;
        rd_idx[0][0] = 5'd5;
        #1;
        chk("cdb_bypass", 32'(rd_tag[0][0]), 104);
        tick();
        idle();
        rd_idx[0][0] = 5'd5;
        #1;
        chk("cdb_table", 32'(rd_tag[0][0]), 104);
        cdb_valid  = 1'b1;
        cdb_tag[0] = 6'd40;
        wr_en      = 2'b01;
        wr_idx[0]  = 5'd5;
        wr_tag[0]  = 6'd44;
        tick();
        idle();
        rd_idx[0][0] = 5'd5;
        #1;
        chk("write_beats_cdb", 32'(rd_tag[0][0]), 44);

        rd_idx[0][0] = 5'd3;
        rd_idx[0][1] = 5'd5;
        rst_n = 1'b0;
        #1;
        chk("midreset_r3", 32'(rd_tag[0][0]), 67);
        chk("midreset_r5", 32'(rd_tag[0][1]), 69);
        tick();
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 4; i++) begin
            ckpt_take = 1'b1;
            #1;
            chk("alloc_id", 32'(ckpt_id), i);
            tick();
        end
        chk("full_after4", 32'(ckpt_full), 1);
        ckpt_take = 1'b1;
        tick();
        ckpt_take = 1'b0;
        #1;
        chk("full_after5", 32'(ckpt_full), 1);
        free_en = 1'b1;
        free_id = 2'd1;
        tick();
        idle();
        #1;
        chk("free1_id", 32'(ckpt_id), 1);
        chk("free1_full", 32'(ckpt_full), 0);

        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        wr_en     = 2'b01;
        wr_idx[0] = 5'd7;
        wr_tag[0] = 6'd40;
        tick();
        idle();
        ckpt_take = 1'b1;
        #1;
        chk("ck0_id", 32'(ckpt_id), 0);
        tick();
        idle();
        wr_en     = 2'b01;
        wr_idx[0] = 5'd7;
        wr_tag[0] = 6'd50;
        ckpt_take = 1'b1;
        #1;
        chk("ck1_id", 32'(ckpt_id), 1);
        tick();
        idle();
        rd_idx[0][0] = 5'd7;
        #1;
        chk("r7_renamed", 32'(rd_tag[0][0]), 50);
        chk("ck2_id", 32'(ckpt_id), 2);
        cdb_valid  = 1'b1;
        cdb_tag[0] = 6'd40;
        tick();
        idle();
        restore_en = 1'b1;
        restore_id = 2'd0;
        wr_en      = 2'b01;
        wr_idx[0]  = 5'd9;
        wr_tag[0]  = 6'd60;
        ckpt_take  = 1'b1;
        tick();
        idle();
        rd_idx[0][0] = 5'd7;
        rd_idx[0][1] = 5'd9;
        #1;
        chk("restore_r7", 32'(rd_tag[0][0]), 104);
        chk("restore_drop_wr", 32'(rd_tag[0][1]), 73);
        chk("restore_id_free", 32'(ckpt_id), 0);
        chk("restore_full", 32'(ckpt_full), 0);

        ckpt_take = 1'b1;
        tick();
        idle();
        restore_en = 1'b1;
        restore_id = 2'd2;
        free_en    = 1'b1;
        free_id    = 2'd0;
        #1;
        chk("live0_id", 32'(ckpt_id), 1);
        tick();
        idle();
        rd_idx[0][0] = 5'd7;
        #1;
        chk("noop_restore_r7", 32'(rd_tag[0][0]), 104);
        chk("free0_id", 32'(ckpt_id), 0);
        chk("free0_full", 32'(ckpt_full), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
